// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central sequencer for the 5-stage pipeline.
// Drives the write-enable, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. It resolves load-use hazards, taken-branch squashes and variable-latency
// data-memory handshakes. A timeout state freezes the pipeline when the data memory hangs.
//
// Ports:
//   Clk, Rst_n            clock (rising edge), asynchronous active-low reset
//   ID_rs/ID_rt/ID_useRt  source registers of the instruction in ID
//   EX_Mem2R/EX_rfWeSel   load flag and destination register of the instruction in EX
//   MEM_memReq, dm_ready  data-memory access in MEM and its completion
//   branch_taken          EX resolved a taken branch/jump
//   err_clr               leaves MEM_ERR and retries the access
//   dm_req                data-memory request strobe
//   *_we/*_flush          pipeline register load enables and clears
//   MEMWB_bubble          MEM/WB captures a NOP
//   mem_err               memory timeout flag
//   stall_cycles          saturating count of cycles with PC_we = 0
//   flush_count           saturating count of honoured branch flushes
//
// Optional build macro: HZD_PERF_CNT_EN builds the performance counters. Without it,
// stall_cycles and flush_count are tied to zero.

module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_useRt,
  input  logic             EX_Mem2R,
  input  logic [4:0]       EX_rfWeSel,
  input  logic             MEM_memReq,
  input  logic             dm_ready,
  input  logic             branch_taken,
  input  logic             err_clr,
  output logic             dm_req,
  output logic             PC_we,
  output logic             IFID_we,
  output logic             IFID_flush,
  output logic             IDEX_we,
  output logic             IDEX_flush,
  output logic             EXMEM_we,
  output logic             MEMWB_we,
  output logic             MEMWB_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {StRun, StMemWait, StMemErr} state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       mem_stall;
  logic       load_use;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StRun;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    mem_stall = MEM_memReq & ~dm_ready;
    load_use  = EX_Mem2R & (EX_rfWeSel != 5'd0) &
                ((EX_rfWeSel == ID_rs) | (ID_useRt & (EX_rfWeSel == ID_rt)));

    state_d = state_q;
    wait_d  = wait_q;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d = StMemWait;
          wait_d  = 8'd1;
        end
      end
      StMemWait: begin
        if (!MEM_memReq || dm_ready) begin
          state_d = StRun;
          wait_d  = 8'd0;
        end else if (wait_q == 8'(MEM_TIMEOUT)) begin
          state_d = StMemErr;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StMemErr: begin
        if (err_clr) begin
          state_d = StRun;
          wait_d  = 8'd0;
        end
      end
      default: begin
        state_d = StRun;
        wait_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    // Normal flow is the default; each hazard class overrides what it must.
    dm_req       = MEM_memReq;
    PC_we        = 1'b1;
    IFID_we      = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_we      = 1'b1;
    IDEX_flush   = 1'b0;
    EXMEM_we     = 1'b1;
    MEMWB_we     = 1'b1;
    MEMWB_bubble = 1'b0;
    mem_err      = 1'b0;

    if (state_q == StMemErr) begin
      dm_req   = 1'b0;
      PC_we    = 1'b0;
      IFID_we  = 1'b0;
      IDEX_we  = 1'b0;
      EXMEM_we = 1'b0;
      MEMWB_we = 1'b0;
      mem_err  = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything up to EX/MEM; WB drains with a bubble. Branch and load-use are
      // re-evaluated once the access completes since EX/ID contents are held.
      PC_we        = 1'b0;
      IFID_we      = 1'b0;
      IDEX_we      = 1'b0;
      EXMEM_we     = 1'b0;
      MEMWB_bubble = 1'b1;
    end else if (branch_taken) begin
      // Squashing ID also kills any load-use hazard of that instruction.
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (load_use) begin
      PC_we      = 1'b0;
      IFID_we    = 1'b0;
      IDEX_flush = 1'b1;
    end

    // Hold the reset values regardless of inputs while reset is asserted.
    if (!Rst_n) begin
      dm_req       = 1'b0;
      PC_we        = 1'b1;
      IFID_we      = 1'b1;
      IFID_flush   = 1'b0;
      IDEX_we      = 1'b1;
      IDEX_flush   = 1'b0;
      EXMEM_we     = 1'b1;
      MEMWB_we     = 1'b1;
      MEMWB_bubble = 1'b0;
      mem_err      = 1'b0;
    end
  end

`ifdef HZD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PC_we && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
      if (IFID_flush && (flush_q != {CNT_W{1'b1}})) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Expected control vectors are pushed to a
// scoreboard queue as each cycle's stimulus is driven and popped when the outputs settle.

module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 16;

  // Code bits: PC_we, IFID_we, IFID_flush, IDEX_we, IDEX_flush, EXMEM_we, MEMWB_we,
  // MEMWB_bubble, mem_err
  localparam logic [8:0] Norm9   = 9'b110101100;
  localparam logic [8:0] Stall9  = 9'b000000110;
  localparam logic [8:0] Branch9 = 9'b111111100;
  localparam logic [8:0] Lu9     = 9'b000111100;
  localparam logic [8:0] Err9    = 9'b000000001;

  logic             Clk, Rst_n;
  logic [4:0]       ID_rs, ID_rt, EX_rfWeSel;
  logic             ID_useRt, EX_Mem2R, MEM_memReq, dm_ready, branch_taken, err_clr;
  logic             dm_req, PC_we, IFID_we, IFID_flush, IDEX_we, IDEX_flush;
  logic             EXMEM_we, MEMWB_we, MEMWB_bubble, mem_err;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [9:0]       outv;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;
  sb_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_useRt(ID_useRt),
    .EX_Mem2R(EX_Mem2R), .EX_rfWeSel(EX_rfWeSel), .MEM_memReq(MEM_memReq),
    .dm_ready(dm_ready), .branch_taken(branch_taken), .err_clr(err_clr), .dm_req(dm_req),
    .PC_we(PC_we), .IFID_we(IFID_we), .IFID_flush(IFID_flush), .IDEX_we(IDEX_we),
    .IDEX_flush(IDEX_flush), .EXMEM_we(EXMEM_we), .MEMWB_we(MEMWB_we),
    .MEMWB_bubble(MEMWB_bubble), .mem_err(mem_err), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  assign outv = {dm_req, PC_we, IFID_we, IFID_flush, IDEX_we, IDEX_flush, EXMEM_we, MEMWB_we,
                 MEMWB_bubble, mem_err};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clocked cycle: stimulus already driven at the falling edge.
  task automatic cyc(input string tag, input logic dmr, input logic [8:0] code);
    sb_t e;
    sb_q.push_back('{tag, {dmr, code}});
    #1;
    e = sb_q.pop_front();
    check(e.tag, {22'd0, outv}, {22'd0, e.exp});
    if (!code[8]) exp_stall++;
    if (code[6]) exp_flush++;
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_useRt = 1'b0; EX_Mem2R = 1'b0; EX_rfWeSel = 5'd0;
    MEM_memReq = 1'b0; dm_ready = 1'b0; branch_taken = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    idle_inputs();
    Rst_n = 1'b0;
    // Hazard inputs during reset must not leak through.
    EX_Mem2R = 1'b1; EX_rfWeSel = 5'd5; ID_rs = 5'd5; MEM_memReq = 1'b1;
    #2;
    check("reset_outputs", {22'd0, outv}, {22'd0, 1'b0, Norm9});
    check("reset_stall_cnt", {16'd0, stall_cycles}, 32'd0);
    check("reset_flush_cnt", {16'd0, flush_count}, 32'd0);
    idle_inputs();
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    cyc("normal", 1'b0, Norm9);

    // Load-use on rs: exactly one bubble, then the load moves on to MEM.
    EX_Mem2R = 1'b1; EX_rfWeSel = 5'd5; ID_rs = 5'd5;
    cyc("lu_rs", 1'b0, Lu9);
    EX_Mem2R = 1'b0; EX_rfWeSel = 5'd0; MEM_memReq = 1'b1; dm_ready = 1'b1;
    cyc("lu_release", 1'b1, Norm9);
    idle_inputs();
    EX_Mem2R = 1'b1; EX_rfWeSel = 5'd0; ID_rs = 5'd0;
    cyc("lu_r0", 1'b0, Norm9);
    EX_rfWeSel = 5'd5; ID_rs = 5'd3; ID_rt = 5'd5; ID_useRt = 1'b0;
    cyc("lu_rt_unused", 1'b0, Norm9);
    ID_useRt = 1'b1;
    cyc("lu_rt_used", 1'b0, Lu9);
    idle_inputs();

    // Three wait cycles then completion.
    MEM_memReq = 1'b1;
    for (int i = 0; i < 3; i++) cyc("mem_wait3", 1'b1, Stall9);
    dm_ready = 1'b1;
    cyc("mem_done", 1'b1, Norm9);
    idle_inputs();
    err_clr = 1'b1;
    cyc("err_clr_in_run", 1'b0, Norm9);
    idle_inputs();

    // Branch together with load-use, then branch held across a memory stall.
    branch_taken = 1'b1; EX_Mem2R = 1'b1; EX_rfWeSel = 5'd7; ID_rs = 5'd7;
    cyc("branch_lu", 1'b0, Branch9);
    idle_inputs();
    branch_taken = 1'b1; MEM_memReq = 1'b1;
    cyc("branch_stall0", 1'b1, Stall9);
    cyc("branch_stall1", 1'b1, Stall9);
    dm_ready = 1'b1;
    cyc("branch_release", 1'b1, Branch9);
    idle_inputs();

    // Asynchronous reset in MEM_WAIT.
    MEM_memReq = 1'b1;
    cyc("pre_rst_stall0", 1'b1, Stall9);
    cyc("pre_rst_stall1", 1'b1, Stall9);
    #2 Rst_n = 1'b0;
    #1;
    check("async_rst_wait", {22'd0, outv}, {22'd0, 1'b0, Norm9});
    check("async_rst_wait_err", {31'd0, mem_err}, 32'd0);
    exp_stall = 0; exp_flush = 0;
    MEM_memReq = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    cyc("post_rst_run", 1'b0, Norm9);

    // Timeout: 1 RUN cycle + 15 MEM_WAIT cycles, then MEM_ERR.
    MEM_memReq = 1'b1;
    for (int i = 0; i < 16; i++) cyc("timeout_wait", 1'b1, Stall9);
    cyc("timeout_err0", 1'b0, Err9);
    cyc("timeout_err1", 1'b0, Err9);
    err_clr = 1'b1;
    cyc("err_clr_pulse", 1'b0, Err9);
    err_clr = 1'b0; dm_ready = 1'b1;
    cyc("err_retry", 1'b1, Norm9);
    dm_ready = 1'b0;

    // Re-enter MEM_ERR, then reset asynchronously.
    for (int i = 0; i < 16; i++) cyc("timeout2_wait", 1'b1, Stall9);
    cyc("timeout2_err", 1'b0, Err9);
    check("stall_cnt_total", {16'd0, stall_cycles},
`ifdef HZD_PERF_CNT_EN
          32'(exp_stall));
`else
          32'd0);
`endif
    check("flush_cnt_total", {16'd0, flush_count},
`ifdef HZD_PERF_CNT_EN
          32'(exp_flush));
`else
          32'd0);
`endif
    #2 Rst_n = 1'b0;
    #1;
    check("async_rst_err", {22'd0, outv}, {22'd0, 1'b0, Norm9});
    check("rst_clears_stall_cnt", {16'd0, stall_cycles}, 32'd0);
    exp_stall = 0; exp_flush = 0;
    MEM_memReq = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    cyc("post_rst_err_run", 1'b0, Norm9);

`ifdef HZD_PERF_CNT_EN
    // Park in MEM_ERR long enough to saturate the stall counter.
    MEM_memReq = 1'b1;
    for (int i = 0; i < 16; i++) cyc("sat_wait", 1'b1, Stall9);
    repeat (65540) @(negedge Clk);
    #1;
    check("stall_cnt_sat", {16'd0, stall_cycles}, 32'h0000_FFFF);
    check("err_held", {31'd0, mem_err}, 32'd1);
`endif

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It generates the write-enable, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It handles load-use hazards, taken-branch squash and variable-latency data-memory handshakes, with a timeout state that freezes the pipeline on a hung memory.

Parameters:
MEM_TIMEOUT, 15, max cycles spent in MEM_WAIT without dm_ready before entering MEM_ERR (1..255)
CNT_W, 16, width of the optional performance counters

Ports:
Clk  in  1  pipeline clock, rising edge
Rst_n  in  1  asynchronous active-low reset
ID_rs  in  5  rs field of instruction in ID
ID_rt  in  5  rt field of instruction in ID
ID_useRt  in  1  ID instruction reads rt
EX_Mem2R  in  1  instruction in EX is a load
EX_rfWeSel  in  5  destination register of instruction in EX
MEM_memReq  in  1  instruction in MEM accesses data memory
dm_ready  in  1  data memory completes the current access this cycle
branch_taken  in  1  EX resolved a taken branch/jump
err_clr  in  1  one-cycle pulse; leave MEM_ERR and retry
dm_req  out  1  data-memory request strobe
PC_we  out  1  PC update enable
IFID_we  out  1  IF/ID load enable
IFID_flush  out  1  IF/ID clear to NOP
IDEX_we  out  1  ID/EX load enable
IDEX_flush  out  1  ID/EX clear to NOP (RegW/MemW = 0)
EXMEM_we  out  1  EX/MEM load enable
MEMWB_we  out  1  MEM/WB load enable
MEMWB_bubble  out  1  MEM/WB captures Mem2R=0, RegW=0
mem_err  out  1  memory timeout flag
stall_cycles  out  CNT_W  stall-cycle count (optional feature)
flush_count  out  CNT_W  branch-flush count (optional feature)

Behaviour:
- FSM states: RUN, MEM_WAIT, MEM_ERR. Reset enters RUN, clears wait_cnt and the counters.
- During reset all outputs are 0, except PC_we, IFID_we, IDEX_we, EXMEM_we and MEMWB_we, which are 1.
- Outputs are combinational from state and inputs. Only the state, wait_cnt and the counters are registered.
- mem_stall = MEM_memReq & ~dm_ready, valid in RUN and MEM_WAIT.
- dm_req = MEM_memReq in RUN and MEM_WAIT; 0 in MEM_ERR.
- load_use = EX_Mem2R & (EX_rfWeSel != 0) & ((EX_rfWeSel == ID_rs) | (ID_useRt & (EX_rfWeSel == ID_rt))).
- Priority, highest first: MEM_ERR, then mem_stall, then branch_taken, then load_use, then normal.
  - MEM_ERR: all *_we = 0, all flush/bubble = 0, mem_err = 1.
  - mem_stall: PC_we, IFID_we, IDEX_we and EXMEM_we = 0; MEMWB_we = 1, MEMWB_bubble = 1; no flushes. A pending branch_taken or load_use is ignored this cycle and re-evaluated when the stall releases, because the EX/ID contents are held.
  - branch_taken: all we = 1; IFID_flush = 1 and IDEX_flush = 1. A simultaneous load_use is ignored because its ID instruction is squashed.
  - load_use: PC_we = 0, IFID_we = 0, IDEX_flush = 1; EXMEM_we and MEMWB_we = 1. Exactly one bubble is inserted per hazard.
  - normal: all we = 1; flushes and bubble = 0.
- Transitions:
  - RUN -> MEM_WAIT when mem_stall; wait_cnt is loaded with 1.
  - MEM_WAIT -> RUN when dm_ready. The access completes that cycle and the pipeline advances the same cycle.
  - MEM_WAIT with mem_stall: wait_cnt increments. When wait_cnt == MEM_TIMEOUT and dm_ready = 0, go to MEM_ERR.
  - MEM_WAIT with MEM_memReq dropped (not expected): return to RUN.
  - MEM_ERR -> RUN on err_clr. The access is retried because EX/MEM was held.
  - err_clr outside MEM_ERR is ignored.
- A zero-wait access (dm_ready high in the request cycle) never leaves RUN.
- Asynchronous reset mid-MEM_WAIT or mid-MEM_ERR aborts immediately to RUN, with wait_cnt = 0 and mem_err = 0.

Optional Feature:
HZD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments every cycle PC_we = 0 (any cause, including MEM_ERR).
  - flush_count increments every cycle branch_taken is honoured (IFID_flush = 1).
  - Both counters saturate at all-ones and are cleared by reset only.
- Undefined: stall_cycles and flush_count are tied to 0 and no counter logic is built. The ports remain present.

Test Plan:
- EX_Mem2R = 1, EX_rfWeSel = 5, ID_rs = 5 -> PC_we = 0, IFID_we = 0, IDEX_flush = 1 for exactly 1 cycle. Next cycle, with the load now in MEM, all we = 1 and no flush.
- Same hazard with EX_rfWeSel = 0 -> no stall. ID_rt = 5 with ID_useRt = 0 -> no stall.
- MEM_memReq = 1, dm_ready low for 3 cycles then high -> dm_req high for 4 cycles; PC_we through EXMEM_we = 0 and MEMWB_bubble = 1 for 3 cycles; state RUN on the 4th-cycle edge.
- MEM_memReq = 1, dm_ready held 0 -> mem_err rises after MEM_TIMEOUT (15) wait cycles with all we = 0 and dm_req = 0. err_clr pulse -> RUN, dm_req reasserted.
- branch_taken with load_use in the same cycle -> IFID_flush = IDEX_flush = 1, PC_we = 1. branch_taken during a memory stall -> flush only in the cycle dm_ready arrives.
- Rst_n asserted asynchronously mid-MEM_WAIT -> state RUN and mem_err = 0 without a clock edge. With HZD_PERF_CNT_EN, counters read 0 after reset and saturate at 0xFFFF under forced stall.
